// File: rtl/downstream_pkg.sv
// Shared widths, types and saturating arithmetic for the downstream
// (exchange-to-client) reporting blocks.
package downstream_pkg;

  localparam int CLIENT_W = 5;
  localparam int AMOUNT_W = 32;

  typedef logic [CLIENT_W-1:0] client_id_t;
  typedef logic [AMOUNT_W-1:0] amount_t;

  // Unsigned add clamped to the all-ones value of a `width`-bit field (width <= 64).
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned width);
    logic [64:0] sum;
    logic [64:0] limit;
    sum   = {1'b0, a} + {1'b0, b};
    limit = (65'd1 << width) - 65'd1;
    return (sum > limit) ? limit[63:0] : sum[63:0];
  endfunction

endpackage

// File: rtl/client_cancel_bank.sv
// Per-client (total, count) flop table: saturating update on ack, sync clear-all,
// write-first combinational read of the addressed entry. One update per cycle, no backpressure.
module client_cancel_bank #(
  parameter int CLIENT_W = downstream_pkg::CLIENT_W,
  parameter int AMOUNT_W = downstream_pkg::AMOUNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ack,
  input  logic [CLIENT_W-1:0] client_id,
  input  logic [AMOUNT_W-1:0] amount,
  output logic [AMOUNT_W-1:0] rd_total,
  output logic [AMOUNT_W-1:0] rd_count
);
  import downstream_pkg::*;

  localparam int DEPTH = 1 << CLIENT_W;

  logic [AMOUNT_W-1:0] total_q [DEPTH];
  logic [AMOUNT_W-1:0] count_q [DEPTH];

  logic [AMOUNT_W-1:0] cur_total;
  logic [AMOUNT_W-1:0] cur_count;
  logic [AMOUNT_W-1:0] nxt_total;
  logic [AMOUNT_W-1:0] nxt_count;

  assign cur_total = total_q[client_id];
  assign cur_count = count_q[client_id];

  // Read mux selects on ack so an X amount never reaches the read port when idle.
  always_comb begin
    nxt_total = AMOUNT_W'(sat_add(64'(cur_total), 64'(amount), unsigned'(AMOUNT_W)));
    nxt_count = AMOUNT_W'(sat_add(64'(cur_count), 64'd1, unsigned'(AMOUNT_W)));
    rd_total  = ack ? nxt_total : cur_total;
    rd_count  = ack ? nxt_count : cur_count;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        total_q[i] <= '0;
        count_q[i] <= '0;
      end
    end else if (ack) begin
      total_q[client_id] <= nxt_total;
      count_q[client_id] <= nxt_count;
    end
  end

endmodule

// File: rtl/downstream_top.sv
// Per-client cancel accumulator; registered readout of the addressed client's
// post-update totals, 1-cycle latency, accepts one cancel every cycle (no backpressure).
module downstream_top #(
  parameter int CLIENT_W = downstream_pkg::CLIENT_W,
  parameter int AMOUNT_W = downstream_pkg::AMOUNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ack,
  input  logic [CLIENT_W-1:0] client_id,
  input  logic [AMOUNT_W-1:0] amount,
  output logic [AMOUNT_W-1:0] total_cancel,
  output logic [AMOUNT_W-1:0] cancelled_orders
);

  logic [AMOUNT_W-1:0] rd_total;
  logic [AMOUNT_W-1:0] rd_count;

  client_cancel_bank #(
    .CLIENT_W (CLIENT_W),
    .AMOUNT_W (AMOUNT_W)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .ack       (ack),
    .client_id (client_id),
    .amount    (amount),
    .rd_total  (rd_total),
    .rd_count  (rd_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      total_cancel     <= '0;
      cancelled_orders <= '0;
    end else begin
      total_cancel     <= rd_total;
      cancelled_orders <= rd_count;
    end
  end

endmodule

// File: tb/tb_downstream_top.sv
// Scoreboard bench for downstream_top: a reference table predicts each edge's readout.
module tb_downstream_top;

  typedef struct packed {
    logic [31:0] t;
    logic [31:0] c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ack;
  logic [4:0]  client_id;
  logic [31:0] amount;
  logic [31:0] total_cancel;
  logic [31:0] cancelled_orders;

  int checks   = 0;
  int failures = 0;

  exp_t        exp_q[$];
  logic [31:0] m_total [32];
  logic [31:0] m_count [32];

  always #5 clk = ~clk;

  downstream_top dut (
    .clk              (clk),
    .rst              (rst),
    .ack              (ack),
    .client_id        (client_id),
    .amount           (amount),
    .total_cancel     (total_cancel),
    .cancelled_orders (cancelled_orders)
  );

  function automatic logic [31:0] clamp_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // Drive one cycle, advance the reference table, queue the expected readout.
  task automatic drive(input bit r, input bit a, input logic [4:0] id, input logic [31:0] amt);
    exp_t e;
    rst       = r;
    ack       = a;
    client_id = id;
    amount    = amt;
    if (r) begin
      for (int i = 0; i < 32; i++) begin
        m_total[i] = '0;
        m_count[i] = '0;
      end
      e = '0;
    end else begin
      if (a) begin
        m_total[id] = clamp_add(m_total[id], amt);
        m_count[id] = clamp_add(m_count[id], 32'd1);
      end
      e.t = m_total[id];
      e.c = m_count[id];
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    drive(1, 0, 5'h00, 32'h0);
    drive(1, 0, 5'h00, 32'h0);
    void'(exp_q.pop_front());
    e = exp_q.pop_front();
    checks++;
    if (total_cancel !== 32'h0 || cancelled_orders !== 32'h0 || e !== 64'h0) begin
      failures++;
      $display("FAIL reset_state total=%h count=%h required 0/0", total_cancel, cancelled_orders);
    end
    drive(0, 0, 5'h1B, 32'hx);
    e = exp_q.pop_front();
    checks++;
    if (total_cancel !== 32'h0 || cancelled_orders !== 32'h0 || total_cancel !== e.t || cancelled_orders !== e.c) begin
      failures++;
      $display("FAIL reset_idle_1b total=%h count=%h required 0/0", total_cancel, cancelled_orders);
    end
  endtask

  task automatic test_accumulate();
    exp_t e;
    logic [31:0] ct [4] = '{32'hC5, 32'h18A, 32'h24F, 32'h24F};
    logic [31:0] cc [4] = '{32'd1, 32'd2, 32'd3, 32'd3};
    for (int i = 0; i < 4; i++) begin
      drive(0, (i < 3), 5'h1B, (i < 3) ? 32'hC5 : 32'hx);
      e = exp_q.pop_front();
      checks++;
      if (total_cancel !== ct[i] || cancelled_orders !== cc[i] || total_cancel !== e.t || cancelled_orders !== e.c) begin
        failures++;
        $display("FAIL accumulate[%0d] total=%h count=%h required %h/%h", i, total_cancel, cancelled_orders, ct[i], cc[i]);
      end
    end
  endtask

  task automatic test_isolation();
    exp_t e;
    logic [4:0]  id [3] = '{5'h05, 5'h05, 5'h1B};
    logic        ak [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] ct [3] = '{32'h0, 32'h10, 32'h24F};
    logic [31:0] cc [3] = '{32'd0, 32'd1, 32'd3};
    for (int i = 0; i < 3; i++) begin
      drive(0, ak[i], id[i], ak[i] ? 32'h10 : 32'hx);
      e = exp_q.pop_front();
      checks++;
      if (total_cancel !== ct[i] || cancelled_orders !== cc[i] || total_cancel !== e.t || cancelled_orders !== e.c) begin
        failures++;
        $display("FAIL isolation[%0d] total=%h count=%h required %h/%h", i, total_cancel, cancelled_orders, ct[i], cc[i]);
      end
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    logic [31:0] am [3] = '{32'hFFFF_FFF0, 32'h20, 32'h1};
    logic [31:0] ct [3] = '{32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] cc [3] = '{32'd1, 32'd2, 32'd3};
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 5'h00, am[i]);
      e = exp_q.pop_front();
      checks++;
      if (total_cancel !== ct[i] || cancelled_orders !== cc[i] || total_cancel !== e.t || cancelled_orders !== e.c) begin
        failures++;
        $display("FAIL saturation[%0d] total=%h count=%h required %h/%h", i, total_cancel, cancelled_orders, ct[i], cc[i]);
      end
    end
  endtask

  task automatic test_reset_priority();
    exp_t e;
    logic [4:0] id [3] = '{5'h1B, 5'h05, 5'h00};
    drive(1, 1, 5'h1B, 32'h55);
    e = exp_q.pop_front();
    checks++;
    if (total_cancel !== 32'h0 || cancelled_orders !== 32'h0 || e !== 64'h0) begin
      failures++;
      $display("FAIL reset_priority total=%h count=%h required 0/0", total_cancel, cancelled_orders);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, id[i], 32'hx);
      e = exp_q.pop_front();
      checks++;
      if (total_cancel !== 32'h0 || cancelled_orders !== 32'h0 || total_cancel !== e.t || cancelled_orders !== e.c) begin
        failures++;
        $display("FAIL post_reset_read[%h] total=%h count=%h required 0/0", id[i], total_cancel, cancelled_orders);
      end
    end
  endtask

  task automatic test_x_tolerance();
    exp_t e;
    drive(0, 1, 5'h05, 32'h7);
    e = exp_q.pop_front();
    checks++;
    if (total_cancel !== 32'h7 || cancelled_orders !== 32'd1 || total_cancel !== e.t || cancelled_orders !== e.c) begin
      failures++;
      $display("FAIL x_preload total=%h count=%h required 7/1", total_cancel, cancelled_orders);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 5'h05, 32'hx);
      e = exp_q.pop_front();
      checks++;
      if (total_cancel !== 32'h7 || cancelled_orders !== 32'd1 || total_cancel !== e.t || cancelled_orders !== e.c) begin
        failures++;
        $display("FAIL x_hold[%0d] total=%h count=%h required 7/1", i, total_cancel, cancelled_orders);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 60; i++) begin
      drive(0, ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), $urandom_range(0, 32'h0FFF_FFFF));
      e = exp_q.pop_front();
      checks++;
      if (total_cancel !== e.t || cancelled_orders !== e.c) begin
        failures++;
        $display("FAIL back_to_back[%0d] id=%h total=%h count=%h required %h/%h", i, client_id, total_cancel, cancelled_orders, e.t, e.c);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    ack       = 1'b0;
    client_id = '0;
    amount    = '0;
    test_reset();
    test_accumulate();
    test_isolation();
    test_saturation();
    test_reset_priority();
    test_x_tolerance();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
